// File: rtl/fetch_ctrl_pkg.sv
// Shared opcode constants and fetch-sequencer state encoding.
package fetch_ctrl_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OP_NOP  = 5'h00;
    localparam logic [OP_W-1:0] OP_HALT = 5'h1F;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_pc_reg.sv
// Program counter: load has priority over increment; increment wraps modulo 2^AW.
module fetch_ctrl_pc_reg #(
    parameter int              AW       = 8,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          load,
    input  logic          incr,
    input  logic [AW-1:0] load_value,
    output logic [AW-1:0] pc
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (enable) begin
            if (load) begin
                pc <= load_value;
            end else if (incr) begin
                pc <= pc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, registers IF/ID, handles start/halt/stall/branch.
//   state   | meaning
//   FS_IDLE | waiting for start, nothing fetched
//   FS_RUN  | fetching one word per cycle into IF/ID
//   FS_HALT | HALT fetched; PC parked until branch or start
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int            AW       = 8,
    parameter int            IW       = 16,
    parameter int            OPW      = OP_W,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          start,
    input  logic          stall,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_target,
    input  logic [IW-1:0] i_datain,
    output logic [AW-1:0] i_addr,
    output logic [IW-1:0] id_ir,
    output logic          id_valid,
    output logic          halted,
    output logic [15:0]   fetch_count
);

    localparam logic [IW-1:0] NOP_WORD = {OP_NOP, {(IW-OPW){1'b0}}};

    fetch_state_t  state;
    logic          word_is_halt;
    logic          pc_load;
    logic          pc_incr;
    logic [AW-1:0] pc_load_value;

    assign word_is_halt = (i_datain[IW-1 -: OPW] == OP_HALT);

    always_comb begin
        pc_load       = 1'b0;
        pc_incr       = 1'b0;
        pc_load_value = branch_target;
        case (state)
            FS_IDLE: begin
                if (start) begin
                    pc_load       = 1'b1;
                    pc_load_value = RESET_PC;
                end
            end
            FS_RUN: begin
                if (branch_taken) begin
                    pc_load = 1'b1;
                end else if (!stall && !word_is_halt) begin
                    pc_incr = 1'b1;
                end
            end
            FS_HALT: begin
                if (branch_taken) begin
                    pc_load = 1'b1;
                end else if (start) begin
                    pc_load       = 1'b1;
                    pc_load_value = RESET_PC;
                end
            end
            default: ;
        endcase
    end

    fetch_ctrl_pc_reg #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .load       (pc_load),
        .incr       (pc_incr),
        .load_value (pc_load_value),
        .pc         (i_addr)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= FS_IDLE;
            id_ir       <= NOP_WORD;
            id_valid    <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= 16'h0000;
        end else if (enable) begin
            case (state)
                FS_IDLE: begin
                    id_valid <= 1'b0;
                    if (start) begin
                        state <= FS_RUN;
                    end
                end
                FS_RUN: begin
                    if (branch_taken) begin
                        id_ir    <= NOP_WORD;
                        id_valid <= 1'b0;
                    end else if (!stall) begin
                        id_ir    <= i_datain;
                        id_valid <= 1'b1;
                        if (fetch_count != 16'hFFFF) begin
                            fetch_count <= fetch_count + 16'd1;
                        end
                        if (word_is_halt) begin
                            state  <= FS_HALT;
                            halted <= 1'b1;
                        end
                    end
                end
                FS_HALT: begin
                    // A late branch flushes even under stall; otherwise stall holds IF/ID.
                    if (branch_taken) begin
                        id_ir    <= NOP_WORD;
                        id_valid <= 1'b0;
                        halted   <= 1'b0;
                        state    <= FS_RUN;
                    end else begin
                        if (!stall) begin
                            id_ir    <= NOP_WORD;
                            id_valid <= 1'b0;
                        end
                        if (start) begin
                            halted <= 1'b0;
                            state  <= FS_RUN;
                        end
                    end
                end
                default: begin
                    state    <= FS_IDLE;
                    id_valid <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the 16-bit pipelined CPU.
- Owns the program counter and drives the 8-bit address of the combinational instruction memory.
- Registers the returned word into the IF/ID stage.
- Handles start, halt detection, hazard stalls and branch redirect/flush.
- Sits between the instruction memory and the decode stage; the hazard unit and branch logic feed it.

Parameters:
- AW, 8, instruction address width (PC width).
- IW, 16, instruction word width.
- OPW, 5, opcode field width (bits IW-1 : IW-OPW).
- RESET_PC, 0, PC value on reset and on start.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  global run enable; 0 freezes all state.
- start  in  1  single-cycle pulse; begins execution at RESET_PC.
- stall  in  1  hazard-unit stall request; holds PC and IF/ID.
- branch_taken  in  1  redirect request from the execute stage.
- branch_target  in  AW  redirect address.
- i_datain  in  IW  instruction word from memory, combinational in i_addr.
- i_addr  out  AW  instruction memory address; always equals the PC register.
- id_ir  out  IW  IF/ID instruction register.
- id_valid  out  1  id_ir holds a real fetched instruction.
- halted  out  1  fetch stopped on HALT.
- fetch_count  out  16  number of instructions issued to ID, saturating.

Behaviour:
- Reset (async, active-high) values:
  - state=IDLE, pc=RESET_PC, id_ir=NOP, id_valid=0, halted=0, fetch_count=0.
  - Reset mid-operation aborts immediately; no partial state survives.
- NOP is {`NOP, zeros}. HALT is detected when i_datain[IW-1:IW-OPW]==`HALT. Both encodings come from define.v.
- Memory is combinational, so i_addr=pc and i_datain are sampled the same cycle. Fetch latency is 1 clock: address at cycle n appears in id_ir at n+1.
- enable=0 in any state: all registers hold and all inputs are ignored, including start and branch_taken.
- IDLE:
  - id_valid=0, pc held.
  - start=1 -> RUN, pc<=RESET_PC; nothing is fetched that cycle.
- RUN, priority branch_taken > stall > normal:
  - Branch: pc<=branch_target, id_ir<=NOP, id_valid<=0 (flush the wrong-path instruction). A HALT fetched in the same cycle is discarded. A stall in the same cycle is overridden.
  - Stall: pc, id_ir and id_valid hold. fetch_count does not increment.
  - Normal, non-HALT word: id_ir<=i_datain, id_valid<=1, pc<=pc+1 mod 2^AW (255 wraps to 0), fetch_count++.
  - Normal, HALT word: id_ir<=i_datain, id_valid<=1, fetch_count++, pc holds, state->HALTED, halted<=1.
- HALTED:
  - Without stall: id_ir<=NOP, id_valid<=0. With stall: hold.
  - branch_taken=1 (an older branch resolving after HALT was fetched): pc<=branch_target, flush, halted<=0, state->RUN. This takes priority over start.
  - start=1: pc<=RESET_PC, halted<=0, state->RUN.
- start while in RUN is ignored.
- fetch_count saturates at 16'hFFFF; it is cleared only by reset.

Decomposition:
- Opcode constants (`HALT, `NOP), register field codes, and new `AW/`IW widths go in the shared define.v.
- State encoding (IDLE=2'd0, RUN=2'd1, HALTED=2'd2) goes in define.v as `FS_IDLE, `FS_RUN, `FS_HALT.
- One natural sub-module: pc_reg, the PC register with load/increment/hold and wrap. The FSM and IF/ID register stay in fetch_ctrl.

Test Plan:
- Reset, then start with a straight-line program at addresses 0..3 -> i_addr steps 0,1,2,3; id_ir matches each word one cycle later; id_valid=1 from the second RUN cycle; fetch_count=4.
- stall held for 2 cycles while i_addr=2 -> i_addr stays 2 and id_ir holds the word from address 1 for 2 cycles; fetch_count does not increment.
- branch_taken with branch_target=8'h05 while i_addr=3, with stall=1 in the same cycle -> next cycle i_addr=5, id_ir=NOP, id_valid=0; the word at address 5 appears in id_ir the following cycle.
- HALT at address 9 -> id_ir=HALT, halted=1, i_addr stays 9; one cycle later id_ir=NOP, id_valid=0; a later branch_taken to 8'h02 -> halted=0 and fetch resumes at 2.
- PC=8'hFF with a non-HALT word -> next i_addr=8'h00 (wrap); reset asserted mid-RUN -> all outputs return to reset values immediately; enable=0 for 3 cycles -> everything frozen, and a start pulse during that window is ignored.
